// File: rtl/pp_cfg_sequencer_pkg.sv
// Shared types and descriptor layout for the post-process config sequencer.
package pp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } seq_state_t;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned WORD_CNT = 6;
  localparam int unsigned DESC_W   = WORD_W * WORD_CNT;

  // Descriptor word indices
  localparam int unsigned W_FLAGS = 0;
  localparam int unsigned W_DIMS  = 1;
  localparam int unsigned W_WADDR = 2;
  localparam int unsigned W_RADDR = 3;
  localparam int unsigned W_LEN   = 4;
  localparam int unsigned W_BTT   = 5;

  // Field positions inside their words
  localparam int unsigned OCH_LSB   = 8;
  localparam int unsigned OCH_W     = 16;
  localparam int unsigned IMGW_LSB  = 0;
  localparam int unsigned IMGH_LSB  = 12;
  localparam int unsigned IMG_DIM_W = 12;
  localparam int unsigned TOTAL_LSB = 16;
  localparam int unsigned TOTAL_W   = 16;

  localparam logic [3:0] PP_IDLE = 4'd0;
  localparam logic [3:0] PP_WORK = 4'd5;

  function automatic logic [WORD_W-1:0] desc_word(input logic [DESC_W-1:0] d,
                                                  input logic [2:0]        k);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < WORD_CNT; i++)
      if (k == 3'(i)) w = d[i*WORD_W +: WORD_W];
    return w;
  endfunction

endpackage

// File: rtl/pp_desc_fifo.sv
// Register FIFO holding queued layer descriptors; read data is the current head.
module pp_desc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 192
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full queue may still accept.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pp_cfg_sequencer.sv
// Layer controller: streams queued post-process descriptors over ppconfig and
// tracks post-process status until each layer finishes.
module pp_cfg_sequencer
  import pp_seq_pkg::*;
#(
  parameter int unsigned DESC_DEPTH  = 4,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [DESC_W-1:0] desc_data,
  output logic              m_axis_ppconfig_tvalid,
  input  logic              m_axis_ppconfig_tready,
  output logic [WORD_W-1:0] m_axis_ppconfig_tdata,
  input  logic [3:0]        status_post,
  output logic              seq_busy,
  output logic              layer_done,
  output logic [15:0]       layers_done,
  output logic              err_cfg,
  output logic              err_timeout,
  input  logic              err_clear
);

  localparam bit                   WD_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_EN ? TIMEOUT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [2:0]           IDX_LAST = 3'(WORD_CNT - 1);

  seq_state_t           state;
  logic [DESC_W-1:0]    hold;
  logic [2:0]           idx;
  logic [TIMEOUT_W-1:0] wd_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DESC_W-1:0] fifo_head;
  logic              pop;

  logic [OCH_W-1:0]     o_ch;
  logic [IMG_DIM_W-1:0] img_w;
  logic [IMG_DIM_W-1:0] img_h;
  logic [TOTAL_W-1:0]   total_len;
  logic                 cfg_bad;

  assign desc_ready = ~fifo_full;
  assign pop        = (state == S_LOAD);
  assign seq_busy   = (state != S_IDLE);

  pp_desc_fifo #(
    .DEPTH (DESC_DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (desc_valid & desc_ready),
    .push_data (desc_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_ch      = hold[W_FLAGS*WORD_W + OCH_LSB   +: OCH_W];
  assign img_w     = hold[W_DIMS*WORD_W  + IMGW_LSB  +: IMG_DIM_W];
  assign img_h     = hold[W_DIMS*WORD_W  + IMGH_LSB  +: IMG_DIM_W];
  assign total_len = hold[W_LEN*WORD_W   + TOTAL_LSB +: TOTAL_W];
  assign cfg_bad   = (o_ch == '0) || (o_ch[2:0] != 3'd0) || (img_w == '0) ||
                     (img_h == '0) || (total_len == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      hold                   <= '0;
      idx                    <= '0;
      wd_cnt                 <= '0;
      m_axis_ppconfig_tvalid <= 1'b0;
      m_axis_ppconfig_tdata  <= '0;
      layer_done             <= 1'b0;
      layers_done            <= '0;
      err_cfg                <= 1'b0;
      err_timeout            <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        S_IDLE: if (enable && !fifo_empty) state <= S_LOAD;
        S_LOAD: begin
          hold  <= fifo_head;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (cfg_bad) begin
            err_cfg <= 1'b1;
            state   <= S_IDLE;
          end else begin
            idx                    <= '0;
            m_axis_ppconfig_tvalid <= 1'b1;
            m_axis_ppconfig_tdata  <= desc_word(hold, 3'd0);
            state                  <= S_SEND;
          end
        end
        S_SEND: begin
          // tvalid is always high here, so tready alone marks the handshake.
          if (m_axis_ppconfig_tready) begin
            if (idx == IDX_LAST) begin
              m_axis_ppconfig_tvalid <= 1'b0;
              wd_cnt                 <= '0;
              state                  <= S_WAIT_BUSY;
            end else begin
              idx                   <= idx + 3'd1;
              m_axis_ppconfig_tdata <= desc_word(hold, idx + 3'd1);
            end
          end
        end
        S_WAIT_BUSY: begin
          if (status_post != PP_IDLE) begin
            state <= S_WAIT_DONE;
          end else if (WD_EN && wd_cnt == WD_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (status_post == PP_IDLE) begin
            layer_done  <= 1'b1;
            layers_done <= layers_done + 16'd1;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (err_clear) begin
        err_cfg     <= 1'b0;
        err_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pp_cfg_sequencer.sv
// Scoreboard bench for pp_cfg_sequencer with a behavioural post-process status responder.
module tb_pp_cfg_sequencer;

  localparam int WORK_LEN = 50;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         desc_valid;
  logic         desc_ready;
  logic [191:0] desc_data;
  logic         tvalid;
  logic         tready;
  logic [31:0]  tdata;
  logic [3:0]   status_post;
  logic         seq_busy;
  logic         layer_done;
  logic [15:0]  layers_done;
  logic         err_cfg;
  logic         err_timeout;
  logic         err_clear;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int hs_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int resp_mode = 0;  // 0 normal, 1 one-cycle status pulse, 2 status stays idle
  bit bp_en = 0;
  bit prev_tv = 0;
  logic [3:0] bp_pat = 4'b1001;
  int bp_ph = 0;

  pp_cfg_sequencer #(
    .DESC_DEPTH  (4),
    .TIMEOUT_W   (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enable                 (enable),
    .desc_valid             (desc_valid),
    .desc_ready             (desc_ready),
    .desc_data              (desc_data),
    .m_axis_ppconfig_tvalid (tvalid),
    .m_axis_ppconfig_tready (tready),
    .m_axis_ppconfig_tdata  (tdata),
    .status_post            (status_post),
    .seq_busy               (seq_busy),
    .layer_done             (layer_done),
    .layers_done            (layers_done),
    .err_cfg                (err_cfg),
    .err_timeout            (err_timeout),
    .err_clear              (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [191:0] make_desc(input logic [15:0] och, input logic [11:0] h,
                                             input logic [11:0] w, input logic [15:0] total,
                                             input logic [31:0] seed);
    logic [191:0] d;
    d[31:0]    = {8'h00, och, 8'h55};
    d[63:32]   = {7'd0, seed[0], h, w};
    d[95:64]   = 32'h1000_0000 + seed;
    d[127:96]  = 32'h2000_0000 ^ (seed << 4);
    d[159:128] = {total, 16'd64};
    d[191:160] = {11'd0, 21'(seed * 3 + 1)};
    return d;
  endfunction

  function automatic bit model_ok(input logic [15:0] och, input logic [11:0] h,
                                  input logic [11:0] w, input logic [15:0] total);
    return (och != 0) && (och % 8 == 0) && (h != 0) && (w != 0) && (total != 0);
  endfunction

  // Scoreboard: every accepted word is popped and compared just before its handshake edge.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rst_n && tvalid) begin
        if (!tready) stall_cnt++;
        else begin
          hs_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL word: got %h, no word expected", tdata);
          end else begin
            w = exp_q.pop_front();
            if (tdata !== w) begin
              n_bad++;
              $display("FAIL word: got %h, required %h", tdata, w);
            end
          end
        end
      end
      if (rst_n && layer_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        tready = bp_pat[bp_ph];
        bp_ph  = (bp_ph + 1) % 4;
      end else tready = 1'b1;
    end
  end

  // Post-process status model, triggered by the end of a config stream.
  initial begin
    status_post = 4'd0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_tv && !tvalid) begin
        if (resp_mode == 0) begin
          repeat (2) @(negedge clk);
          for (int s = 1; s < 5; s++) begin
            status_post = 4'(s);
            @(negedge clk);
          end
          status_post = 4'd5;
          repeat (WORK_LEN) @(negedge clk);
          status_post = 4'd0;
        end else if (resp_mode == 1) begin
          @(negedge clk);
          status_post = 4'd1;
          @(negedge clk);
          status_post = 4'd0;
        end
      end
      prev_tv = tvalid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_desc(input logic [15:0] och, input logic [11:0] h, input logic [11:0] w,
                           input logic [15:0] total, input logic [31:0] seed, output bit accepted);
    logic [191:0] d;
    d          = make_desc(och, h, w, total, seed);
    desc_data  = d;
    desc_valid = 1'b1;
    accepted   = desc_ready;
    step(1);
    desc_valid = 1'b0;
    if (accepted && model_ok(och, h, w, total))
      for (int k = 0; k < 6; k++) exp_q.push_back(d[32*k +: 32]);
  endtask

  task automatic wait_layers(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    n_cmp++;
    if (done_cnt < target) begin
      n_bad++;
      $display("FAIL %s: layers seen %0d, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; desc_valid = 1'b0; desc_data = '0; err_clear = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    n_cmp++;
    if ({tvalid, seq_busy, layer_done, err_cfg, err_timeout, desc_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 000001",
               {tvalid, seq_busy, layer_done, err_cfg, err_timeout, desc_ready});
    end
    n_cmp++;
    if (layers_done !== 16'd0) begin
      n_bad++; $display("FAIL reset_layers_done: got %0d, required 0", layers_done);
    end
    n_cmp++;
    if (tdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_tdata: got %h, required 0", tdata);
    end
  endtask

  task automatic test_basic;
    bit acc;
    int hs0;
    enable = 1'b1; resp_mode = 0; hs0 = hs_cnt;
    push_desc(16'h0040, 12'd8, 12'd8, 16'd1, 32'd1, acc);
    wait_layers(1, 400, "basic_done");
    step(3);
    n_cmp++;
    if (hs_cnt - hs0 !== 6) begin
      n_bad++; $display("FAIL basic_words: got %0d, required 6", hs_cnt - hs0);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++; $display("FAIL basic_pulse: got %0d pulse cycles, required 1", done_cnt);
    end
    n_cmp++;
    if (layers_done !== 16'd1) begin
      n_bad++; $display("FAIL basic_count: got %0d, required 1", layers_done);
    end
    n_cmp++;
    if (seq_busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle: seq_busy %b, required 0", seq_busy);
    end
  endtask

  task automatic test_backpressure;
    bit acc;
    int hs0, st0;
    hs0 = hs_cnt; st0 = stall_cnt; bp_en = 1'b1;
    push_desc(16'h0080, 12'd16, 12'd4, 16'd7, 32'd2, acc);
    wait_layers(2, 600, "bp_done");
    bp_en = 1'b0;
    step(2);
    n_cmp++;
    if (hs_cnt - hs0 !== 6) begin
      n_bad++; $display("FAIL bp_words: got %0d, required 6", hs_cnt - hs0);
    end
    n_cmp++;
    if ((stall_cnt > st0) !== 1'b1) begin
      n_bad++; $display("FAIL bp_stalls: got %0d stall cycles, required >0", stall_cnt - st0);
    end
    n_cmp++;
    if (layers_done !== 16'd2) begin
      n_bad++; $display("FAIL bp_count: got %0d, required 2", layers_done);
    end
  endtask

  task automatic test_invalid;
    bit acc;
    int hs0;
    hs0 = hs_cnt;
    push_desc(16'd12, 12'd8, 12'd8, 16'd1, 32'd3, acc);
    push_desc(16'd0,  12'd8, 12'd8, 16'd1, 32'd4, acc);
    push_desc(16'd32, 12'd5, 12'd9, 16'd2, 32'd5, acc);
    wait_layers(3, 600, "inv_done");
    step(3);
    n_cmp++;
    if (hs_cnt - hs0 !== 6) begin
      n_bad++; $display("FAIL inv_words: got %0d, required 6", hs_cnt - hs0);
    end
    n_cmp++;
    if (done_cnt !== 3 || layers_done !== 16'd3) begin
      n_bad++; $display("FAIL inv_count: got %0d/%0d, required 3/3", done_cnt, layers_done);
    end
    n_cmp++;
    if (err_cfg !== 1'b1) begin
      n_bad++; $display("FAIL inv_err_cfg: got %b, required 1", err_cfg);
    end
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    n_cmp++;
    if (err_cfg !== 1'b0) begin
      n_bad++; $display("FAIL inv_err_clear: got %b, required 0", err_cfg);
    end
  endtask

  task automatic test_watchdog;
    bit acc;
    int n, i;
    resp_mode = 2;
    push_desc(16'h0010, 12'd2, 12'd2, 16'd3, 32'd6, acc);
    n = 0;
    while (tvalid !== 1'b1 && n < 50) begin step(1); n++; end
    n = 0;
    while (tvalid !== 1'b0 && n < 50) begin step(1); n++; end
    for (i = 1; i <= 40; i++) begin
      step(1);
      if (err_timeout === 1'b1) break;
    end
    n_cmp++;
    if (i !== 16) begin
      n_bad++; $display("FAIL wd_latency: fired after %0d cycles, required 16", i);
    end
    step(2);
    n_cmp++;
    if ({seq_busy, err_timeout} !== 2'b01) begin
      n_bad++; $display("FAIL wd_state: busy/err %b, required 01", {seq_busy, err_timeout});
    end
    n_cmp++;
    if (layers_done !== 16'd3 || done_cnt !== 3) begin
      n_bad++; $display("FAIL wd_count: got %0d/%0d, required 3/3", layers_done, done_cnt);
    end
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    n_cmp++;
    if (err_timeout !== 1'b0) begin
      n_bad++; $display("FAIL wd_clear: got %b, required 0", err_timeout);
    end
    resp_mode = 0;
  endtask

  task automatic test_queue_full;
    bit acc;
    int n_acc, hs0;
    enable = 1'b0; n_acc = 0; hs0 = hs_cnt;
    for (int k = 0; k < 5; k++) begin
      push_desc(16'h0008 * 16'(k + 1), 12'd4, 12'd4, 16'd1, 32'(10 + k), acc);
      if (acc) n_acc++;
    end
    n_cmp++;
    if (n_acc !== 4) begin
      n_bad++; $display("FAIL full_accepts: got %0d, required 4", n_acc);
    end
    n_cmp++;
    if (desc_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_ready: got %b, required 0", desc_ready);
    end
    step(20);
    n_cmp++;
    if (hs_cnt !== hs0) begin
      n_bad++; $display("FAIL gate_words: got %0d words, required 0", hs_cnt - hs0);
    end
    enable = 1'b1;
    wait_layers(7, 1500, "b2b_done");
    step(3);
    n_cmp++;
    if (layers_done !== 16'd7 || exp_q.size() !== 0) begin
      n_bad++; $display("FAIL b2b_count: got %0d, pending %0d, required 7, 0",
                        layers_done, exp_q.size());
    end
  endtask

  task automatic test_quick_status;
    bit acc;
    resp_mode = 1;
    push_desc(16'h0018, 12'd3, 12'd3, 16'd1, 32'd20, acc);
    wait_layers(8, 300, "quick_done");
    step(2);
    n_cmp++;
    if (layers_done !== 16'd8) begin
      n_bad++; $display("FAIL quick_count: got %0d, required 8", layers_done);
    end
    resp_mode = 0;
  endtask

  task automatic test_reset_mid;
    bit acc;
    int hs0, n, d0;
    enable = 1'b1; hs0 = hs_cnt;
    push_desc(16'h0040, 12'd8, 12'd8, 16'd1, 32'd30, acc);
    push_desc(16'h0040, 12'd8, 12'd8, 16'd1, 32'd31, acc);
    n = 0;
    while (hs_cnt < hs0 + 3 && n < 100) begin step(1); n++; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tvalid, seq_busy, desc_ready} !== 3'b001) begin
      n_bad++; $display("FAIL rst_mid_flags: got %b, required 001", {tvalid, seq_busy, desc_ready});
    end
    n_cmp++;
    if (layers_done !== 16'd0) begin
      n_bad++; $display("FAIL rst_mid_count: got %0d, required 0", layers_done);
    end
    exp_q.delete();
    d0 = done_cnt;
    step(1);
    rst_n = 1'b1;
    step(20);
    n_cmp++;
    if (hs_cnt !== hs0 + 3 || tvalid !== 1'b0 || done_cnt !== d0) begin
      n_bad++; $display("FAIL rst_mid_drop: words %0d tvalid %b layers %0d, required 3 0 %0d",
                        hs_cnt - hs0, tvalid, done_cnt, d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_invalid();
    test_watchdog();
    test_queue_full();
    test_quick_status();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
